// File: rtl/cm_sketch_aging.sv
// Count-min sketch with conservative update, clear and optional aging.
// Ports: clk, rst_n, input_valid/ready/addr, clear_req, decay_req,
//   busy, est_valid/addr/cnt. Define CM_SKETCH_DECAY_EN to honour decay_req.
module cm_sketch_aging #(
  parameter int ADDR_SIZE    = 28,
  parameter int CNT_SIZE     = 32,
  parameter int W            = 16,
  parameter int NUM_HASH     = 4,
  parameter int HASH_SIZE    = $clog2(W),
  parameter bit CONSERVATIVE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic [ADDR_SIZE-1:0] input_addr,
  input  logic                 clear_req,
  input  logic                 decay_req,
  output logic                 busy,
  output logic                 est_valid,
  output logic [ADDR_SIZE-1:0] est_addr,
  output logic [CNT_SIZE-1:0]  est_cnt
);

  localparam int NSLICE = (ADDR_SIZE + HASH_SIZE - 1) / HASH_SIZE;
  localparam int PADW   = NSLICE * HASH_SIZE;
  localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
  localparam logic [HASH_SIZE-1:0] LAST_COL = HASH_SIZE'(W - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;

  state_t               state_q, state_d;
  logic [HASH_SIZE-1:0] sweep_col_q, sweep_col_d;
  logic                 decay_go;
  logic                 accept;

  logic                 s1_valid_q;
  logic [ADDR_SIZE-1:0] s1_addr_q;
  logic [HASH_SIZE-1:0] s1_col_q [NUM_HASH];
  logic [HASH_SIZE-1:0] in_col   [NUM_HASH];

  logic [CNT_SIZE-1:0]  cnt_q [NUM_HASH][W];
  logic [CNT_SIZE-1:0]  rd_v  [NUM_HASH];
  logic [CNT_SIZE-1:0]  min_v;
  logic [CNT_SIZE-1:0]  est_next;
  logic [NUM_HASH-1:0]  inc;

  // Row hash: rotate left by 7*row, then fold HASH_SIZE-bit slices by XOR.
  function automatic logic [HASH_SIZE-1:0] hash_col(
    input logic [ADDR_SIZE-1:0] a,
    input int                   row
  );
    logic [2*ADDR_SIZE-1:0] dbl;
    logic [PADW-1:0]        p;
    logic [HASH_SIZE-1:0]   h;
    int                     sh;
    sh  = (7 * row) % ADDR_SIZE;
    dbl = {a, a} << sh;
    p   = '0;
    p[ADDR_SIZE-1:0] = dbl[2*ADDR_SIZE-1:ADDR_SIZE];
    h   = '0;
    for (int k = 0; k < NSLICE; k++)
      h ^= p[k*HASH_SIZE +: HASH_SIZE];
    return h;
  endfunction

`ifdef CM_SKETCH_DECAY_EN
  assign decay_go = decay_req;
`else
  logic unused_decay;
  assign unused_decay = decay_req;
  assign decay_go     = 1'b0;
`endif

  assign input_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign accept      = input_valid && input_ready && !clear_req;

  always_comb begin
    for (int i = 0; i < NUM_HASH; i++)
      in_col[i] = hash_col(input_addr, i);
  end

  // S1 read and update decision
  always_comb begin
    min_v = CNT_MAX;
    for (int i = 0; i < NUM_HASH; i++) begin
      rd_v[i] = cnt_q[i][s1_col_q[i]];
      if (rd_v[i] < min_v)
        min_v = rd_v[i];
    end
    inc = '0;
    for (int i = 0; i < NUM_HASH; i++)
      inc[i] = (rd_v[i] != CNT_MAX) &&
               (!CONSERVATIVE || (rd_v[i] == min_v));
    est_next = (min_v == CNT_MAX) ? CNT_MAX : min_v + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    sweep_col_d = sweep_col_q;
    unique case (state_q)
      IDLE: begin
        if (decay_go)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid_q) begin
          state_d     = SWEEP;
          sweep_col_d = '0;
        end
      end
      SWEEP: begin
        sweep_col_d = sweep_col_q + 1'b1;
        if (sweep_col_q == LAST_COL)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_req) begin
      state_d     = IDLE;
      sweep_col_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sweep_col_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_col_q <= sweep_col_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      for (int i = 0; i < NUM_HASH; i++)
        s1_col_q[i] <= '0;
      est_valid  <= 1'b0;
      est_addr   <= '0;
      est_cnt    <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= input_addr;
        for (int i = 0; i < NUM_HASH; i++)
          s1_col_q[i] <= in_col[i];
      end
      est_valid <= s1_valid_q && !clear_req;
      if (s1_valid_q && !clear_req) begin
        est_addr <= s1_addr_q;
        est_cnt  <= est_next;
      end
    end
  end

  // Sweep and S1 writes never overlap: DRAIN waits for S1 to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_HASH; i++)
        for (int j = 0; j < W; j++)
          cnt_q[i][j] <= '0;
    end else if (clear_req) begin
      for (int i = 0; i < NUM_HASH; i++)
        for (int j = 0; j < W; j++)
          cnt_q[i][j] <= '0;
    end else if (state_q == SWEEP) begin
      for (int i = 0; i < NUM_HASH; i++)
        cnt_q[i][sweep_col_q] <= cnt_q[i][sweep_col_q] >> 1;
    end else if (s1_valid_q) begin
      for (int i = 0; i < NUM_HASH; i++)
        if (inc[i])
          cnt_q[i][s1_col_q[i]] <= rd_v[i] + 1'b1;
    end
  end

endmodule
